program_loader: RTL and testbench

//  Boot-time instruction loader directly upstream of the 8-bit single-cycle processor.

---
 rtl/loader_pkg.sv | 18 +
 rtl/loader_timeout.sv | 38 +++
 rtl/program_loader.sv | 144 ++++++++++++++
 tb/tb_program_loader.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared definitions for the boot-time program loader: FSM state encoding
// and the error codes reported on err_code.
package loader_pkg;

   typedef enum logic [2:0] {
      LEN  = 3'd0,
      LOAD = 3'd1,
      CSUM = 3'd2,
      RUN  = 3'd3,
      ERR  = 3'd4
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_CSUM    = 2'd1;
   localparam logic [1:0] ERR_LEN     = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

endpackage

// File: rtl/loader_timeout.sv
// Idle-cycle watchdog: counts enabled cycles without a clear and flags the
// cycle that would be the TIMEOUT_CYC-th idle one. TIMEOUT_CYC=0 disables it.
module loader_timeout #(
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expired
);

   generate
      if (TIMEOUT_CYC == 0) begin : g_off
         assign expired = 1'b0;
      end else begin : g_on
         localparam int W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
         localparam logic [W-1:0] LAST = W'(TIMEOUT_CYC - 1);

         logic [W-1:0] count;

         // expired marks the last allowed idle cycle, so the FSM leaves on the
         // same edge at which the count would reach TIMEOUT_CYC.
         assign expired = en && (count == LAST);

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               count <= '0;
            end else if (clr || !en) begin
               count <= '0;
            end else if (!expired) begin
               count <= count + 1'b1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives length, program bytes and checksum over valid/ready,
// writes the bytes to instruction memory and releases the core on a good sum.
module program_loader
   import loader_pkg::*;
#(
   parameter int PROG_DEPTH  = 256,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   input  logic       reload,
   output logic       imem_we,
   output logic [7:0] imem_addr,
   output logic [7:0] imem_wdata,
   output logic       cpu_run,
   output logic       busy,
   output logic       err,
   output logic [1:0] err_code,
   output logic [8:0] loaded_len
);

   localparam logic [8:0] DEPTH_L = 9'(PROG_DEPTH);

   state_t     state, state_nxt;
   logic [1:0] code_nxt;
   logic [8:0] cnt;
   logic [7:0] sum;
   logic [8:0] len_in;
   logic       accept;
   logic       expired;

   assign in_ready = (state == LEN) || (state == LOAD) || (state == CSUM);
   assign busy     = (state == LOAD) || (state == CSUM);
   assign cpu_run  = (state == RUN);
   assign err      = (state == ERR);
   assign accept   = in_valid && in_ready;
   // A length byte of zero encodes the full 256-word program.
   assign len_in   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};

   loader_timeout #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clr    (accept),
      .en     (busy),
      .expired(expired)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= LEN;
         err_code <= ERR_NONE;
      end else begin
         state    <= state_nxt;
         err_code <= code_nxt;
      end
   end

   always_comb begin
      // NOTE: every output of this block is defaulted first so no path through
      // the case statement can leave a variable unassigned and infer a latch.
      state_nxt = state;
      code_nxt  = err_code;
      unique case (state)
         LEN: begin
            if (accept) begin
               if (len_in > DEPTH_L) begin
                  state_nxt = ERR;
                  code_nxt  = ERR_LEN;
               end else begin
                  state_nxt = LOAD;
               end
            end
         end
         LOAD: begin
            // An accept in the expiring cycle still counts as a live stream.
            if (accept) begin
               if (cnt == loaded_len - 9'd1) state_nxt = CSUM;
            end else if (expired) begin
               state_nxt = ERR;
               code_nxt  = ERR_TIMEOUT;
            end
         end
         CSUM: begin
            if (accept) begin
               if (in_data == sum) begin
                  state_nxt = RUN;
               end else begin
                  state_nxt = ERR;
                  code_nxt  = ERR_CSUM;
               end
            end else if (expired) begin
               state_nxt = ERR;
               code_nxt  = ERR_TIMEOUT;
            end
         end
         RUN: begin
            if (reload) state_nxt = LEN;
         end
         ERR: begin
            if (reload) begin
               state_nxt = LEN;
               code_nxt  = ERR_NONE;
            end
         end
         default: begin
            state_nxt = LEN;
            code_nxt  = ERR_NONE;
         end
      endcase
   end

   // NOTE: sequential state is updated with non-blocking assignments so every
   // register samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt        <= '0;
         sum        <= '0;
         loaded_len <= '0;
         imem_we    <= 1'b0;
         imem_addr  <= '0;
         imem_wdata <= '0;
      end else begin
         imem_we <= 1'b0;
         if (accept && (state == LEN)) begin
            loaded_len <= len_in;
            cnt        <= '0;
            sum        <= '0;
         end
         if (accept && (state == LOAD)) begin
            imem_we    <= 1'b1;
            imem_addr  <= cnt[7:0];
            imem_wdata <= in_data;
            sum        <= sum + in_data;
            cnt        <= cnt + 9'd1;
         end
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// Directed bench for program_loader: checksum pass/fail, timeout edge,
// async reset mid-load, full 256-byte load, length error and stalled streams.
module tb_program_loader;
   import loader_pkg::*;

   logic       clk;
   logic       reset;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       reload;
   logic       imem_we;
   logic [7:0] imem_addr;
   logic [7:0] imem_wdata;
   logic       cpu_run;
   logic       busy;
   logic       err;
   logic [1:0] err_code;
   logic [8:0] loaded_len;

   logic       s_valid;
   logic [7:0] s_data;
   logic       s_ready;
   logic       s_reload;
   logic       s_we;
   logic [7:0] s_addr;
   logic [7:0] s_wdata;
   logic       s_run;
   logic       s_busy;
   logic       s_err;
   logic [1:0] s_code;
   logic [8:0] s_len;

   int n_checks = 0;
   int n_fail   = 0;

   program_loader u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .reload    (reload),
      .imem_we   (imem_we),
      .imem_addr (imem_addr),
      .imem_wdata(imem_wdata),
      .cpu_run   (cpu_run),
      .busy      (busy),
      .err       (err),
      .err_code  (err_code),
      .loaded_len(loaded_len)
   );

   program_loader #(
      .PROG_DEPTH(16)
   ) u_small (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (s_valid),
      .in_data   (s_data),
      .in_ready  (s_ready),
      .reload    (s_reload),
      .imem_we   (s_we),
      .imem_addr (s_addr),
      .imem_wdata(s_wdata),
      .cpu_run   (s_run),
      .busy      (s_busy),
      .err       (s_err),
      .err_code  (s_code),
      .loaded_len(s_len)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present one byte; returns 1 time unit after the accepting edge.
   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic pulse_reload();
      reload = 1'b1;
      @(posedge clk);
      #1;
      reload = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      reload   = 1'b0;
      s_valid  = 1'b0;
      s_data   = 8'h00;
      s_reload = 1'b0;
      #12;
      check("rst_ready", 32'(in_ready), 32'd1);
      check("rst_run", 32'(cpu_run), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_code", 32'(err_code), 32'd0);
      check("rst_we", 32'(imem_we), 32'd0);
      check("rst_addr", 32'(imem_addr), 32'd0);
      check("rst_len", 32'(loaded_len), 32'd0);
      reset = 1'b1;
      @(posedge clk);
      #1;

      // 1: good 3-byte program, back-to-back
      send(8'h03);
      check("t1_len", 32'(loaded_len), 32'd3);
      check("t1_busy", 32'(busy), 32'd1);
      check("t1_we_len", 32'(imem_we), 32'd0);
      send(8'h21);
      check("t1_w0", {22'd0, imem_we, imem_addr, imem_wdata}, {22'd0, 1'b1, 8'h00, 8'h21});
      send(8'h42);
      check("t1_w1", {22'd0, imem_we, imem_addr, imem_wdata}, {22'd0, 1'b1, 8'h01, 8'h42});
      send(8'h63);
      check("t1_w2", {22'd0, imem_we, imem_addr, imem_wdata}, {22'd0, 1'b1, 8'h02, 8'h63});
      check("t1_run_early", 32'(cpu_run), 32'd0);
      send(8'hC6);
      check("t1_run", 32'(cpu_run), 32'd1);
      check("t1_we_csum", 32'(imem_we), 32'd0);
      check("t1_err", 32'(err), 32'd0);
      check("t1_ready", 32'(in_ready), 32'd0);
      pulse_reload();
      check("t1_reload_run", 32'(cpu_run), 32'd0);
      check("t1_reload_ready", 32'(in_ready), 32'd1);

      // 2: bad checksum
      send(8'h03);
      send(8'h21);
      send(8'h42);
      send(8'h63);
      send(8'h00);
      check("t2_err", 32'(err), 32'd1);
      check("t2_code", 32'(err_code), 32'(ERR_CSUM));
      check("t2_run", 32'(cpu_run), 32'd0);
      check("t2_ready", 32'(in_ready), 32'd0);
      send(8'h05);
      check("t2_ignored_len", 32'(loaded_len), 32'd3);
      pulse_reload();
      check("t2_reload_err", 32'(err), 32'd0);
      check("t2_reload_code", 32'(err_code), 32'd0);
      check("t2_reload_ready", 32'(in_ready), 32'd1);
      check("t2_reload_busy", 32'(busy), 32'd0);

      // 3: timeout exactly 1024 cycles after the last accept
      send(8'h02);
      send(8'h11);
      repeat (1023) @(posedge clk);
      #1;
      check("t3_pre_err", 32'(err), 32'd0);
      check("t3_pre_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      check("t3_code", 32'(err_code), 32'(ERR_TIMEOUT));
      check("t3_err", 32'(err), 32'd1);
      pulse_reload();
      // a byte arriving in the last idle cycle beats the timeout
      send(8'h02);
      send(8'h11);
      repeat (1023) @(posedge clk);
      #1;
      send(8'h22);
      check("t3_late_err", 32'(err), 32'd0);
      check("t3_late_w1", {23'd0, imem_addr, imem_wdata}, {23'd0, 8'h01, 8'h22});
      send(8'h33);
      check("t3_late_run", 32'(cpu_run), 32'd1);
      pulse_reload();

      // 4: asynchronous reset in the middle of a load
      send(8'h05);
      send(8'hAA);
      send(8'hBB);
      check("t4_we_before", 32'(imem_we), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("t4_rst_we", 32'(imem_we), 32'd0);
      check("t4_rst_busy", 32'(busy), 32'd0);
      check("t4_rst_ready", 32'(in_ready), 32'd1);
      check("t4_rst_addr", 32'(imem_addr), 32'd0);
      check("t4_rst_len", 32'(loaded_len), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      send(8'h02);
      send(8'hAA);
      check("t4_w0", {23'd0, imem_addr, imem_wdata}, {23'd0, 8'h00, 8'hAA});
      send(8'hBB);
      check("t4_w1", {23'd0, imem_addr, imem_wdata}, {23'd0, 8'h01, 8'hBB});
      send(8'h65);
      check("t4_run", 32'(cpu_run), 32'd1);
      pulse_reload();

      // 5a: length byte 00 loads 256 words, sum of 0..255 is 0x80
      send(8'h00);
      check("t5_len", 32'(loaded_len), 32'd256);
      for (int i = 0; i < 256; i++) begin
         send(8'(i));
         check("t5_write", {22'd0, imem_we, imem_addr, imem_wdata}, {22'd0, 1'b1, 8'(i), 8'(i)});
      end
      check("t5_csum_state", 32'(busy), 32'd1);
      check("t5_run_early", 32'(cpu_run), 32'd0);
      send(8'h80);
      check("t5_run", 32'(cpu_run), 32'd1);
      check("t5_addr_hold", 32'(imem_addr), 32'hFF);
      pulse_reload();

      // 5b: length 11 exceeds a 16-word memory
      s_valid = 1'b1;
      s_data  = 8'h11;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      check("t5b_err", 32'(s_err), 32'd1);
      check("t5b_code", 32'(s_code), 32'(ERR_LEN));
      check("t5b_we", 32'(s_we), 32'd0);
      check("t5b_len", 32'(s_len), 32'h11);
      check("t5b_ready", 32'(s_ready), 32'd0);
      s_reload = 1'b1;
      @(posedge clk);
      #1;
      s_reload = 1'b0;
      s_valid  = 1'b1;
      s_data   = 8'h10;
      @(posedge clk);
      #1;
      s_valid = 1'b0;
      check("t5b_fit_busy", 32'(s_busy), 32'd1);
      check("t5b_fit_run", 32'(s_run), 32'd0);
      check("t5b_fit_addr", 32'(s_addr), 32'd0);
      check("t5b_fit_wdata", 32'(s_wdata), 32'd0);

      // 6: stalled stream with reload requests while busy
      send(8'h04);
      for (int i = 1; i <= 4; i++) begin
         int gaps;
         gaps = $urandom_range(0, 3);
         repeat (gaps) begin
            in_valid = 1'b0;
            in_data  = 8'hEE;
            reload   = 1'b1;
            @(posedge clk);
            #1;
            reload = 1'b0;
            check("t6_gap_we", 32'(imem_we), 32'd0);
            check("t6_gap_busy", 32'(busy), 32'd1);
         end
         send(8'(i));
         check("t6_write", {22'd0, imem_we, imem_addr, imem_wdata}, {22'd0, 1'b1, 8'(i - 1), 8'(i)});
      end
      pulse_reload();
      check("t6_reload_ignored", 32'(busy), 32'd1);
      send(8'h0A);
      check("t6_run", 32'(cpu_run), 32'd1);
      check("t6_err", 32'(err), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
